// File: rtl/imem_arbiter_if.sv
// Bus bundle between the IMEM arbiter (slave) and its fetch / loader / IMEM-array neighbours (master).
interface imem_arbiter_if #(
    parameter int ADDR_W = 10
);
    logic              fetch_req;
    logic [31:0]       fetch_addr;
    logic [31:0]       fetch_rdata;
    logic              fetch_valid;
    logic              fetch_stall;
    logic              ld_valid;
    logic              ld_ready;
    logic [31:0]       ld_addr;
    logic [31:0]       ld_wdata;
    logic              ld_last;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              boot_done;
    logic [31:0]       perf_stall_cnt;

    modport slave (
        input  fetch_req, fetch_addr, ld_valid, ld_addr, ld_wdata, ld_last, mem_rdata,
        output fetch_rdata, fetch_valid, fetch_stall, ld_ready,
               mem_en, mem_we, mem_addr, mem_wdata, boot_done, perf_stall_cnt
    );

    modport master (
        output fetch_req, fetch_addr, ld_valid, ld_addr, ld_wdata, ld_last, mem_rdata,
        input  fetch_rdata, fetch_valid, fetch_stall, ld_ready,
               mem_en, mem_we, mem_addr, mem_wdata, boot_done, perf_stall_cnt
    );
endinterface

// File: rtl/imem_arbiter.sv
// Shares the single-port IMEM between fetch (read) and the loader (write): boot-load first, then
// fetch priority with a bounded loader wait. Optional stall counter under IMEM_ARB_PERF_EN.
module imem_arbiter #(
    parameter int ADDR_W    = 10,
    parameter int MAX_WAIT  = 8,
    parameter int WAIT_W    = 4,
    parameter int BOOT_SKIP = 0
) (
    input  logic          clk,
    input  logic          rst,
    imem_arbiter_if.slave bus
);
    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam state_e            RST_STATE = (BOOT_SKIP != 0) ? ST_RUN : ST_BOOT;
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MAX_WAIT);

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;

    logic              grant_ld;
    logic              fetch_stall;
    logic              fetch_valid;
    logic              ld_ready;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;

    // Byte addresses map to words; bits outside the IMEM window wrap silently.
    logic [ADDR_W-1:0] ld_word;
    logic [ADDR_W-1:0] fetch_word;
    assign ld_word    = bus.ld_addr[ADDR_W+1:2];
    assign fetch_word = bus.fetch_addr[ADDR_W+1:2];

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        grant_ld    = 1'b0;
        fetch_stall = 1'b1;
        fetch_valid = 1'b0;
        ld_ready    = 1'b0;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = ld_word;

        case (state_q)
            ST_BOOT: begin
                ld_ready = 1'b1;
                mem_en   = bus.ld_valid;
                mem_we   = bus.ld_valid;
                wait_d   = '0;
                if (bus.ld_valid && bus.ld_last)
                    state_d = ST_RUN;
            end
            ST_RUN: begin
                grant_ld = bus.ld_valid && (!bus.fetch_req || (wait_q == WAIT_MAX));
                if (grant_ld) begin
                    mem_en      = 1'b1;
                    mem_we      = 1'b1;
                    mem_addr    = ld_word;
                    ld_ready    = 1'b1;
                    fetch_stall = bus.fetch_req;
                    wait_d      = '0;
                end else begin
                    mem_en      = bus.fetch_req;
                    mem_addr    = fetch_word;
                    fetch_valid = bus.fetch_req;
                    fetch_stall = 1'b0;
                    // Age only a beat that is actually being denied; saturate at the bound.
                    if (!bus.ld_valid)
                        wait_d = '0;
                    else if (wait_q != WAIT_MAX)
                        wait_d = wait_q + 1'b1;
                end
            end
            default: state_d = RST_STATE;
        endcase

        // Reset gates the bus combinationally so a mid-beat reset cannot commit a write.
        if (!rst) begin
            fetch_stall = 1'b1;
            fetch_valid = 1'b0;
            ld_ready    = 1'b0;
            mem_en      = 1'b0;
            mem_we      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RST_STATE;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    assign bus.fetch_rdata = bus.mem_rdata;
    assign bus.fetch_valid = fetch_valid;
    assign bus.fetch_stall = fetch_stall;
    assign bus.ld_ready    = ld_ready;
    assign bus.mem_en      = mem_en;
    assign bus.mem_we      = mem_we;
    assign bus.mem_addr    = mem_addr;
    assign bus.mem_wdata   = bus.ld_wdata;
    assign bus.boot_done   = (state_q == ST_RUN);

`ifdef IMEM_ARB_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            perf_q <= '0;
        else if ((state_q == ST_RUN) && fetch_stall)
            perf_q <= perf_q + 32'd1;
    end

    assign bus.perf_stall_cnt = perf_q;
`else
    assign bus.perf_stall_cnt = 32'h0;
`endif

    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.fetch_addr[1:0], bus.fetch_addr[31:ADDR_W+2],
                                bus.ld_addr[1:0], bus.ld_addr[31:ADDR_W+2]};
endmodule

// File: tb/tb_imem_arbiter.sv
// Randomised scoreboard bench for imem_arbiter: per-cycle predictions from a behavioural model.
module tb_imem_arbiter;
    localparam int AW       = 10;
    localparam int DEPTH    = 1 << AW;
    localparam int MAX_WAIT = 8;
`ifdef IMEM_ARB_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    imem_arbiter_if #(.ADDR_W(AW)) bus ();

    imem_arbiter #(
        .ADDR_W(AW), .MAX_WAIT(MAX_WAIT), .WAIT_W(4), .BOOT_SKIP(0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Behavioural IMEM array hung on the DUT's memory port.
    logic [31:0] imem [0:DEPTH-1];
    assign bus.mem_rdata = imem[bus.mem_addr];
    always @(posedge clk)
        if (bus.mem_en && bus.mem_we)
            imem[bus.mem_addr] <= bus.mem_wdata;

    typedef struct {
        logic        fstall, fvalid, ldrdy, men, mwe, bdone;
        logic [31:0] maddr;
        logic [31:0] rdata;
        logic [31:0] perf;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad   = 0;

    // Reference model state.
    logic [31:0] mdl_mem [0:DEPTH-1];
    bit          m_boot;
    int          m_wait;
    logic [31:0] m_perf;

    // Loader beat currently offered (held until accepted).
    bit          p_v;
    logic [31:0] p_a, p_d;
    bit          p_l;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
        end
    endfunction

    exp_t me;
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            me = sb.pop_front();
            chk("fetch_stall", 32'(bus.fetch_stall), 32'(me.fstall));
            chk("fetch_valid", 32'(bus.fetch_valid), 32'(me.fvalid));
            chk("ld_ready",    32'(bus.ld_ready),    32'(me.ldrdy));
            chk("mem_en",      32'(bus.mem_en),      32'(me.men));
            chk("mem_we",      32'(bus.mem_we),      32'(me.mwe));
            chk("boot_done",   32'(bus.boot_done),   32'(me.bdone));
            chk("perf_cnt",    bus.perf_stall_cnt,   me.perf);
            if (me.men)
                chk("mem_addr", 32'(bus.mem_addr), me.maddr);
            if (me.mwe)
                chk("mem_wdata", bus.mem_wdata, p_d_hist_pop());
            if (me.fvalid)
                chk("fetch_rdata", bus.fetch_rdata, me.rdata);
        end
    end

    // Write data expected on each committing cycle, in order.
    logic [31:0] wd_q[$];
    function automatic logic [31:0] p_d_hist_pop();
        if (wd_q.size() == 0) return 32'hDEAD_0000;
        return wd_q.pop_front();
    endfunction

    function automatic int word_of(input logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    task automatic offer(input logic [31:0] a, input logic [31:0] d, input bit l);
        p_v = 1'b1; p_a = a; p_d = d; p_l = l;
    endtask

    task automatic cyc(input bit r, input bit fr, input logic [31:0] fa);
        exp_t e;
        int   wa, wf;
        bit   acc;
        @(posedge clk);
        #1;
        rst            = r;
        bus.fetch_req  = fr;
        bus.fetch_addr = fa;
        bus.ld_valid   = p_v;
        bus.ld_addr    = p_a;
        bus.ld_wdata   = p_d;
        bus.ld_last    = p_l;
        wa = word_of(p_a);
        wf = word_of(fa);
        e = '{fstall: 1'b0, fvalid: 1'b0, ldrdy: 1'b0, men: 1'b0, mwe: 1'b0, bdone: 1'b0,
              maddr: 32'h0, rdata: 32'h0, perf: (PERF ? m_perf : 32'h0)};
        acc = 1'b0;
        if (!r) begin
            e.fstall = 1'b1;
            e.perf   = 32'h0;
            m_boot   = 1'b1;
            m_wait   = 0;
            m_perf   = 32'h0;
        end else if (m_boot) begin
            e.fstall = 1'b1;
            e.ldrdy  = 1'b1;
            e.men    = p_v;
            e.mwe    = p_v;
            e.maddr  = 32'(wa);
            if (p_v) begin
                acc = 1'b1;
                if (p_l) m_boot = 1'b0;
            end
        end else begin
            e.bdone = 1'b1;
            if (p_v && (!fr || m_wait >= MAX_WAIT)) begin
                e.men = 1'b1; e.mwe = 1'b1; e.ldrdy = 1'b1; e.fstall = fr;
                e.maddr = 32'(wa);
                acc = 1'b1;
                m_wait = 0;
                if (fr) m_perf = m_perf + 32'd1;
            end else begin
                e.men    = fr;
                e.maddr  = 32'(wf);
                e.fvalid = fr;
                e.rdata  = mdl_mem[wf];
                m_wait   = p_v ? ((m_wait < MAX_WAIT) ? m_wait + 1 : m_wait) : 0;
            end
        end
        if (acc) begin
            mdl_mem[wa] = p_d;
            wd_q.push_back(p_d);
            p_v = 1'b0;
        end
        sb.push_back(e);
    endtask

    function automatic logic [31:0] rand_addr();
        return ($urandom_range(0, 3) << 12) | ($urandom_range(0, 63) << 2) | $urandom_range(0, 3);
    endfunction

    task automatic run_rand(input int n);
        for (int i = 0; i < n; i++) begin
            if (!p_v && $urandom_range(0, 2) == 0)
                offer(rand_addr(), $urandom, 1'($urandom_range(0, 1)));
            cyc(1'b1, ($urandom_range(0, 3) != 0), rand_addr());
        end
    endtask

    task automatic boot_image(input int n, input bit rnd);
        for (int i = 0; i < n; i++) begin
            if (rnd) offer(rand_addr(), $urandom, (i == n - 1));
            else     offer(32'(i * 4), 32'hA0 + 32'(i), (i == n - 1));
            cyc(1'b1, 1'($urandom_range(0, 1)), rand_addr());
            if (i == 1) cyc(1'b1, 1'b1, 32'h0);  // bubble: no beat, fetch still held off
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            imem[i]    = 32'h0;
            mdl_mem[i] = 32'h0;
        end
        rst = 1'b0;
        bus.fetch_req = 1'b0; bus.fetch_addr = 32'h0;
        bus.ld_valid = 1'b0; bus.ld_addr = 32'h0; bus.ld_wdata = 32'h0; bus.ld_last = 1'b0;
        m_boot = 1'b1; m_wait = 0; m_perf = 32'h0;
        p_v = 1'b0; p_a = 32'h0; p_d = 32'h0; p_l = 1'b0;

        // Held in reset with a beat and a fetch both asking.
        offer(32'h0, 32'h1111_1111, 1'b1);
        cyc(1'b0, 1'b1, 32'h0);
        cyc(1'b0, 1'b1, 32'h4);
        p_v = 1'b0;

        boot_image(4, 1'b0);
        cyc(1'b1, 1'b1, 32'h8);                 // reads 0xA2 same cycle
        cyc(1'b1, 1'b0, 32'h0);

        // Fetch hogs the port: loader granted on its 9th cycle with fetch stalled.
        offer(32'h4, 32'hBEEF, 1'b0);
        for (int i = 0; i < 12 && p_v; i++)
            cyc(1'b1, 1'b1, 32'hC);
        cyc(1'b1, 1'b1, 32'h4);                 // reads back 0xBEEF

        // Idle fetch: beat accepted at once; 0x1003 wraps onto word 0.
        offer(32'h1003, 32'h5A5A_0001, 1'b0);
        cyc(1'b1, 1'b0, 32'h0);
        cyc(1'b1, 1'b1, 32'h0);

        run_rand(300);

        // Reset in the middle of a denied beat.
        offer(rand_addr(), $urandom, 1'b0);
        cyc(1'b1, 1'b1, rand_addr());
        cyc(1'b0, 1'b1, rand_addr());
        cyc(1'b0, 1'b0, rand_addr());
        p_v = 1'b0;
        cyc(1'b1, 1'b1, 32'h0);
        boot_image(3, 1'b1);
        run_rand(300);

        p_v = 1'b0;
        cyc(1'b1, 1'b0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
